// File: rtl/scr1_dmem_vec_tcm_if.sv
// -----------------------------------------------------------------------------
// scr1_dmem_vec_pkg / scr1_dmem_vec_tcm_if
//
// Purpose : shared DMEM types for the vector TCM and the request/response
//           interface that connects the load/store unit to it.
//
// Package contents:
//   SCR1_DMEM_AWIDTH      byte-address width
//   SCR1_VEC_LANE         number of 32-bit lanes in a vector (LANE)
//   type_vector           LANE x 32-bit packed vector, lane 0 in bits [31:0]
//   type_scr1_mem_cmd_e   RD / WR
//   type_scr1_mem_width_e BYTE / HWORD / WORD / VECTOR
//   type_scr1_mem_resp_e  NOTRDY / RDY_OK / RDY_ER
//
// Interface signals (master = requester, slave = memory):
//   dmem_req      master->slave  request valid
//   dmem_cmd      master->slave  read or write
//   dmem_width    master->slave  access size
//   dmem_addr     master->slave  byte address
//   dmem_wdata    master->slave  store data (narrow stores: lane 0, right-aligned)
//   dmem_req_ack  slave->master  request accepted this cycle
//   dmem_rdata    slave->master  load data, valid in the response cycle only
//   dmem_resp     slave->master  response status
// -----------------------------------------------------------------------------
package scr1_dmem_vec_pkg;

  localparam int unsigned SCR1_DMEM_AWIDTH = 32;
  localparam int unsigned SCR1_VEC_LANE    = 4;

  typedef logic [SCR1_VEC_LANE-1:0][31:0] type_vector;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE   = 2'd0,
    SCR1_MEM_WIDTH_HWORD  = 2'd1,
    SCR1_MEM_WIDTH_WORD   = 2'd2,
    SCR1_MEM_WIDTH_VECTOR = 2'd3
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'd0,
    SCR1_MEM_RESP_RDY_OK = 2'd1,
    SCR1_MEM_RESP_RDY_ER = 2'd2
  } type_scr1_mem_resp_e;

endpackage

interface scr1_dmem_vec_tcm_if;
  import scr1_dmem_vec_pkg::*;

  logic                          dmem_req;
  type_scr1_mem_cmd_e            dmem_cmd;
  type_scr1_mem_width_e          dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr;
  type_vector                    dmem_wdata;
  logic                          dmem_req_ack;
  type_vector                    dmem_rdata;
  type_scr1_mem_resp_e           dmem_resp;

  modport master (
    output dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    input  dmem_req_ack, dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_req, dmem_cmd, dmem_width, dmem_addr, dmem_wdata,
    output dmem_req_ack, dmem_rdata, dmem_resp
  );

endinterface

// File: rtl/scr1_dmem_vec_tcm.sv
// -----------------------------------------------------------------------------
// scr1_dmem_vec_tcm
//
// Purpose : single-port LANE-wide data memory acting as the DMEM responder.
//           Accepts byte/halfword/word/vector accesses, checks range (and
//           optionally alignment) and answers RDY_OK / RDY_ER exactly LATENCY
//           cycles after acceptance. One access is outstanding at a time.
//
// Parameters:
//   DEPTH      rows of LANE 32-bit words
//   BASE_ADDR  byte address of row 0, word 0
//   LATENCY    acceptance-to-response delay in cycles, 1..15
//
// Ports:
//   clk      sole clock
//   rst      synchronous, active-high reset (memory contents are kept)
//   dmem_if  slave side of scr1_dmem_vec_tcm_if
//
// Configuration macro:
//   SCR1_DMEM_MISALIGN_CHK_EN  defined   : misaligned HWORD/WORD/VECTOR -> RDY_ER
//                              undefined : ignored low address bits are masked
// -----------------------------------------------------------------------------
module scr1_dmem_vec_tcm
  import scr1_dmem_vec_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int unsigned LATENCY   = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  scr1_dmem_vec_tcm_if.slave   dmem_if
);

  localparam int unsigned LANE    = SCR1_VEC_LANE;
  localparam int unsigned LSEL_W  = $clog2(LANE);     // word-in-row index width
  localparam int unsigned LANE_SH = LSEL_W + 2;       // byte-in-row bits
  localparam int unsigned WORDS   = DEPTH * LANE;
  localparam int unsigned WIDX_W  = $clog2(WORDS);
  localparam int unsigned OFF_W   = WIDX_W + 2;
  localparam int unsigned ROW_W   = OFF_W - LANE_SH;
  localparam int unsigned CNT_W   = 4;
  localparam logic [32:0] SPAN    = 33'(DEPTH * LANE * 4);

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  type_scr1_mem_cmd_e    cmd_q, cmd_d;
  type_scr1_mem_width_e  width_q, width_d;
  logic [OFF_W-1:0]      off_q, off_d;
  type_vector            wdata_q, wdata_d;
  logic                  err_q, err_d;

  logic [31:0]           mem_q [WORDS];

  // ---------------------------------------------------------------------------
  // Request decode (used only at acceptance)
  // ---------------------------------------------------------------------------
  // A 33-bit subtraction gives the offset and, in bit 32, the borrow that
  // flags addresses below BASE_ADDR.
  logic [32:0]       req_diff;
  logic [31:0]       req_off;
  logic              req_oor;
  logic              req_misalign;
  logic [OFF_W-1:0]  req_off_al;

  assign req_diff = {1'b0, dmem_if.dmem_addr} - {1'b0, BASE_ADDR};
  assign req_off  = req_diff[31:0];
  assign req_oor  = req_diff[32] | ({1'b0, req_off} >= SPAN);

`ifdef SCR1_DMEM_MISALIGN_CHK_EN
  always_comb begin
    req_misalign = 1'b0;
    case (dmem_if.dmem_width)
      SCR1_MEM_WIDTH_HWORD:  req_misalign = req_off[0];
      SCR1_MEM_WIDTH_WORD:   req_misalign = |req_off[1:0];
      SCR1_MEM_WIDTH_VECTOR: req_misalign = |req_off[LANE_SH-1:0];
      default:               req_misalign = 1'b0;
    endcase
  end

  assign req_off_al = req_off[OFF_W-1:0];
`else
  assign req_misalign = 1'b0;

  // Without the check, the sub-access address bits are simply dropped.
  always_comb begin
    req_off_al = req_off[OFF_W-1:0];
    case (dmem_if.dmem_width)
      SCR1_MEM_WIDTH_HWORD:  req_off_al[0]           = 1'b0;
      SCR1_MEM_WIDTH_WORD:   req_off_al[1:0]         = 2'b00;
      SCR1_MEM_WIDTH_VECTOR: req_off_al[LANE_SH-1:0] = '0;
      default:               ;
    endcase
  end
`endif

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  logic req_ack;
  logic resp_cyc;

  // The response cycle is the last BUSY cycle; reset in that cycle abandons it.
  assign resp_cyc = (state_q == ST_BUSY) && (cnt_q == '0) && !rst;

  // NOTE: every variable driven here gets its default first, so no path
  // through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cmd_d   = cmd_q;
    width_d = width_q;
    off_d   = off_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    req_ack = 1'b0;

    case (state_q)
      ST_IDLE: begin
        req_ack = !rst;
        if (dmem_if.dmem_req && req_ack) begin
          cmd_d   = dmem_if.dmem_cmd;
          width_d = dmem_if.dmem_width;
          off_d   = req_off_al;
          wdata_d = dmem_if.dmem_wdata;
          err_d   = req_oor | req_misalign;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) state_d = ST_IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cmd_q   <= SCR1_MEM_CMD_RD;
      width_q <= SCR1_MEM_WIDTH_BYTE;
      off_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cmd_q   <= cmd_d;
      width_q <= width_d;
      off_q   <= off_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

  assign dmem_if.dmem_req_ack = req_ack;

  // ---------------------------------------------------------------------------
  // Datapath: array access in the response cycle
  // ---------------------------------------------------------------------------
  logic [WIDX_W-1:0] word_idx;
  logic [ROW_W-1:0]  row_idx;
  logic [1:0]        byte_sel;
  logic [3:0]        byte_en;
  logic [31:0]       wr_word;
  logic [31:0]       rd_word;
  logic              do_wr;
  logic              do_rd;

  assign word_idx = off_q[OFF_W-1:2];
  assign row_idx  = off_q[OFF_W-1:LANE_SH];
  assign byte_sel = off_q[1:0];
  assign do_wr    = resp_cyc && (cmd_q == SCR1_MEM_CMD_WR) && !err_q;
  assign do_rd    = resp_cyc && (cmd_q == SCR1_MEM_CMD_RD) && !err_q;

  // Narrow store data moves from the low end of lane 0 up to its byte lane.
  assign wr_word = wdata_q[0] << {byte_sel, 3'b000};
  assign rd_word = mem_q[word_idx] >> {byte_sel, 3'b000};

  always_comb begin
    byte_en = 4'b0000;
    case (width_q)
      SCR1_MEM_WIDTH_BYTE:  byte_en = 4'b0001 << byte_sel;
      SCR1_MEM_WIDTH_HWORD: byte_en = 4'b0011 << byte_sel;
      SCR1_MEM_WIDTH_WORD:  byte_en = 4'b1111;
      default:              byte_en = 4'b0000;
    endcase
  end

  // NOTE: the storage array has no reset; contents survive rst and only
  // valid writes change them.
  always_ff @(posedge clk) begin
    if (do_wr) begin
      if (width_q == SCR1_MEM_WIDTH_VECTOR) begin
        for (int i = 0; i < LANE; i++) begin
          mem_q[{row_idx, LSEL_W'(i)}] <= wdata_q[i];
        end
      end else begin
        for (int b = 0; b < 4; b++) begin
          if (byte_en[b]) mem_q[word_idx][8*b +: 8] <= wr_word[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    dmem_if.dmem_rdata = '0;
    if (do_rd) begin
      if (width_q == SCR1_MEM_WIDTH_VECTOR) begin
        for (int i = 0; i < LANE; i++) begin
          dmem_if.dmem_rdata[i] = mem_q[{row_idx, LSEL_W'(i)}];
        end
      end else begin
        dmem_if.dmem_rdata[0] = rd_word;
      end
    end
  end

  always_comb begin
    dmem_if.dmem_resp = SCR1_MEM_RESP_NOTRDY;
    if (resp_cyc) begin
      dmem_if.dmem_resp = err_q ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_RDY_OK;
    end
  end

endmodule
